seq_reduce_gate: RTL and testbench



---
 rtl/seq_reduce_gate.sv | 170 +++++++++++++++++
 tb/tb_seq_reduce_gate.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_reduce_gate.sv
// Serial AND/OR/XOR/NAND reducer: folds a WIDTH-bit operand into one bit, CHUNK bits per clock.
// Optional SEQ_REDUCE_EARLY_EXIT_EN ends the fold as soon as the result is decided.
module seq_reduce_gate #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out,
   output logic             busy
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_NAND = 2'b11;

   generate
      if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
         $error("seq_reduce_gate: WIDTH must be >= 2 and a multiple of CHUNK, CHUNK in 1..WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   // Starting accumulator value for a mode: all-ones for AND-type, zero otherwise.
   function automatic logic mode_identity(input logic [1:0] op);
      logic r;
      case (op)
         MODE_AND:  r = 1'b1;
         MODE_NAND: r = 1'b1;
         MODE_OR:   r = 1'b0;
         MODE_XOR:  r = 1'b0;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   // One fold step; NAND accumulates as AND and is inverted only on output.
   function automatic logic fold_chunk(input logic acc, input logic [CHUNK-1:0] c, input logic [1:0] op);
      logic r;
      case (op)
         MODE_OR:   r = acc | (|c);
         MODE_XOR:  r = acc ^ (^c);
         MODE_AND:  r = acc & (&c);
         MODE_NAND: r = acc & (&c);
         default:   r = acc & (&c);
      endcase
      return r;
   endfunction

   state_t             state_r;
   logic [WIDTH-1:0]   data_r;
   logic [1:0]         mode_r;
   logic               acc_r;
   logic [IDX_W-1:0]   idx_r;

   logic [CHUNK-1:0]   chunk_s;
   logic               fold_s;
   logic               last_s;
   logic               early_s;
   logic               done_s;

   // Select the current chunk (LSB first) and compute the next accumulator value.
   always_comb begin
      chunk_s = data_r[int'(idx_r) * CHUNK +: CHUNK];
      fold_s  = fold_chunk(acc_r, chunk_s, mode_r);
      last_s  = (idx_r == IDX_W'(N - 1));
   end

`ifdef SEQ_REDUCE_EARLY_EXIT_EN
   // A zero under AND/NAND or a one under OR cannot change any more; XOR never decides early.
   always_comb begin
      case (mode_r)
         MODE_AND:  early_s = ~fold_s;
         MODE_NAND: early_s = ~fold_s;
         MODE_OR:   early_s = fold_s;
         MODE_XOR:  early_s = 1'b0;
         default:   early_s = 1'b0;
      endcase
   end
`else
   // Without early exit every operation runs the full N folds.
   always_comb begin
      early_s = 1'b0;
   end
`endif

   // Fold completes on the last chunk, or earlier when the result is already decided.
   always_comb begin
      if (last_s || early_s) begin
         done_s = 1'b1;
      end else begin
         done_s = 1'b0;
      end
   end

   // Control FSM with all handshake outputs registered; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         data_r    <= {WIDTH{1'b0}};
         mode_r    <= MODE_AND;
         acc_r     <= 1'b0;
         idx_r     <= {IDX_W{1'b0}};
         out       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  data_r   <= in_data;
                  mode_r   <= mode;
                  acc_r    <= mode_identity(mode);
                  idx_r    <= {IDX_W{1'b0}};
                  state_r  <= ST_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc_r <= fold_s;
               if (done_s) begin
                  // idx is left alone here so it never wraps past the last chunk.
                  state_r   <= ST_HOLD;
                  out       <= (mode_r == MODE_NAND) ? ~fold_s : fold_s;
                  out_valid <= 1'b1;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  state_r <= ST_RUN;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_r   <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  state_r   <= ST_HOLD;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_reduce_gate.sv
// Scoreboard bench for seq_reduce_gate (WIDTH=8, CHUNK=2): stimulus pushes expected results,
// a negedge monitor models busy/in_ready and checks each result and its fold latency.
module tb_seq_reduce_gate;

   localparam int WIDTH = 8;
   localparam int CHUNK = 2;

`ifdef SEQ_REDUCE_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [1:0]       mode = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out;
   logic             busy;

   seq_reduce_gate #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic exp_out;
      int   exp_folds;
      string name;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor model state.
   bit   mon_en  = 1'b0;
   bit   busy_m  = 1'b0;
   bit   seen_v  = 1'b0;
   logic held_out;
   int   cnt     = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy_m) cnt++;
         check("busy", int'(busy), int'(busy_m));
         check("in_ready", int'(in_ready), int'(!busy_m));
         if (out_valid && !busy_m) begin
            check("unexpected_out_valid", 1, 0);
         end else if (out_valid && !seen_v) begin
            if (sb.size() == 0) begin
               check("sb_empty_on_result", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check({e.name, "_out"}, int'(out), int'(e.exp_out));
               check({e.name, "_folds"}, cnt - 1, e.exp_folds);
            end
            seen_v   = 1'b1;
            held_out = out;
         end else if (out_valid) begin
            check("out_stable", int'(out), int'(held_out));
         end else if (seen_v) begin
            check("out_valid_dropped", 1, 0);
         end
         // Model the edge that follows this sample.
         if (rst) begin
            busy_m = 1'b0;
            seen_v = 1'b0;
         end else if (!busy_m && in_valid) begin
            busy_m = 1'b1;
            seen_v = 1'b0;
            cnt    = 0;
         end else if (busy_m && out_valid && out_ready) begin
            busy_m = 1'b0;
            seen_v = 1'b0;
         end
      end
   end

   // Caller is at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic issue(input logic [7:0] d, input logic [1:0] m, input bit push,
                        input logic eo, input int ef, input string name, output int waits);
      exp_t e;
      if (push) begin
         e.exp_out = eo; e.exp_folds = ef; e.name = name;
         sb.push_back(e);
      end
      in_valid = 1'b1; in_data = d; mode = m;
      waits = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         waits = k;
         if (in_ready) break;
      end
      if (!in_ready) check({name, "_accept_timeout"}, 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      mode     = ~m;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && in_ready && !out_valid) break;
      end
      if (k == 60) check({name, "_idle_timeout"}, 0, 1);
      @(posedge clk); #1;
   endtask

   int w;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out", int'(out), 0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Basic AND and the back-to-back OR pair.
      issue(8'hFF, 2'b00, 1'b1, 1'b1, 4, "and_ff", w);
      check("and_ff_accept_wait", w, 1);
      wait_idle("and_ff");
      issue(8'h00, 2'b01, 1'b1, 1'b0, 4, "or_00", w);
      issue(8'h40, 2'b01, 1'b1, 1'b1, 4, "or_40", w);
      check("b2b_accept_wait", w, 6);
      wait_idle("or_40");

      issue(8'h07, 2'b10, 1'b1, 1'b1, 4, "xor_07", w);  wait_idle("xor_07");
      issue(8'h0F, 2'b10, 1'b1, 1'b0, 4, "xor_0f", w);  wait_idle("xor_0f");
      issue(8'hFF, 2'b11, 1'b1, 1'b0, 4, "nand_ff", w); wait_idle("nand_ff");
      issue(8'h7F, 2'b11, 1'b1, 1'b1, 4, "nand_7f", w); wait_idle("nand_7f");

      // Backpressure: hold the result for five cycles with a stray in_valid pulse.
      out_ready = 1'b0;
      issue(8'h07, 2'b10, 1'b1, 1'b1, 4, "bp_xor_07", w);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("bp_out_valid_hold1", int'(out_valid), 1);
      for (int c = 2; c <= 5; c++) begin
         @(posedge clk); #1;
         in_valid = (c == 3);
         in_data  = 8'h00;
         mode     = 2'b00;
         @(negedge clk);
         check("bp_out_valid_hold", int'(out_valid), 1);
         check("bp_in_ready_low", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_before_transfer", int'(out_valid), 1);
      @(negedge clk);
      check("bp_after_transfer_valid", int'(out_valid), 0);
      check("bp_after_transfer_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Reset sampled at E2 of an AND 0xFF; nothing may be emitted.
      issue(8'hFF, 2'b00, 1'b0, 1'b1, 4, "rst_and_ff", w);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_out_valid", int'(out_valid), 0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      issue(8'h0F, 2'b00, 1'b1, 1'b0, EE ? 3 : 4, "and_0f", w); wait_idle("and_0f");

      // Early-exit sensitive cases.
      issue(8'hFE, 2'b00, 1'b1, 1'b0, EE ? 1 : 4, "and_fe", w); wait_idle("and_fe");
      issue(8'hFE, 2'b10, 1'b1, 1'b1, 4, "xor_fe", w);          wait_idle("xor_fe");

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
